vga_timing_rx: RTL
==================

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Parameters
REQ-001 H_TOTAL_EXP, 800, expected clocks per line (hsync rise to hsync rise).
REQ-002 V_TOTAL_EXP, 525, expected lines per frame (vsync rise to vsync rise).
REQ-003 H_ACT_START, 144, line position of the first active pixel.
REQ-004 V_ACT_START, 35, frame line of the first active line.
REQ-005 H_VALID / V_VALID, 640 / 480, active width / height.
REQ-006 LOCK_FRAMES, 2, consecutive good frames required to lock.

Interface
REQ-007 vga_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 sys_rst_n  in  1  synchronous, active-low reset.
REQ-009 hsync  in  1  active-high horizontal sync pulse.
REQ-010 vsync  in  1  active-high vertical sync pulse.
REQ-011 vga_rgb  in  12  incoming pixel colour.
REQ-012 pix_valid  out  1  registered; captured pixel is active.
REQ-013 pix_x / pix_y  out  10 each  registered; coordinates of the captured pixel; 0 when pix_valid=0.
REQ-014 pix_data  out  12  registered; vga_rgb sample; 0 when pix_valid=0.
REQ-015 frame_start  out  1  one-cycle pulse coinciding with pix_valid at pix_x=0, pix_y=0.
REQ-016 locked  out  1  high in LOCKED state.
REQ-017 lock_lost  out  1  one-cycle pulse on each LOCKED->SEARCH transition.
REQ-018 err_cnt  out  8  saturating count of lock losses.
REQ-019 h_total_meas / v_total_meas  out  10 each  last measured line length / frame line count.

Function
REQ-020 Edges: h_rise = hsync & ~hsync_prev; v_rise = vsync & ~vsync_prev; prev registers are cleared by reset.
REQ-021 Line position p_h is 0 in the cycle h_rise is sampled and +1 each later cycle; p_h saturates at 1023.
REQ-022 Frame line p_v: 0 on h_rise coincident with v_rise; +1 on every other h_rise; saturates at 1023.
REQ-023 On each h_rise: h_total_meas <= previous p_h + 1 (saturating at 1023); the first h_rise after reset does not update it.
REQ-024 On each v_rise: v_total_meas <= previous p_v + 1 (saturating); the first v_rise after reset does not update it.
REQ-025 Line error: h_rise with measured length != H_TOTAL_EXP, or p_h reaching 1023 (timeout).
REQ-026 Frame error: any line error within the frame, v_rise not coincident with h_rise, or measured frame lines != V_TOTAL_EXP.
REQ-027 States: SEARCH, MEASURE, LOCKED; reset state SEARCH; good_frames counter is cleared on reset.
REQ-028 SEARCH -> MEASURE on the first v_rise coincident with h_rise; good_frames <= 0.
REQ-029 MEASURE: at each subsequent v_rise, a good frame increments good_frames and an errored frame clears it; reaching LOCK_FRAMES -> LOCKED.
REQ-030 LOCKED -> SEARCH in the cycle a line or frame error is detected; lock_lost pulses next cycle; err_cnt += 1, saturating at 255.
REQ-031 Active window: LOCKED and H_ACT_START <= p_h < H_ACT_START+H_VALID and V_ACT_START <= p_v < V_ACT_START+V_VALID.
REQ-032 Outputs have 1-cycle latency: the sample at position (p_h, p_v) appears next cycle with pix_x = p_h-H_ACT_START and pix_y = p_v-V_ACT_START.
REQ-033 On an error cycle inside the active window, that sample is suppressed (pix_valid=0).

Reset
REQ-034 With sys_rst_n=0 at a vga_clk edge, all outputs, counters, measurements, and the FSM are reset (outputs 0, state SEARCH), independent of sync inputs.
REQ-035 Mid-frame reset discards partial measurements; relock requires the full SEARCH/MEASURE sequence.

Verification
REQ-036 Ideal 800x525 timing after reset -> locked=1 the cycle after the 3rd vsync rise; the next frame gives frame_start with pix_x=0, pix_y=0, pix_data = rgb at p_h=144, p_v=35.
REQ-037 Locked frame -> exactly 640 pix_valid per active line and 307200 per frame; last pixel pix_x=639, pix_y=479; pix_x/pix_y=0 while invalid.
REQ-038 While locked, one 801-clock line -> locked=0, lock_lost one pulse, err_cnt=1, h_total_meas=801; relock after 3 further good vsync rises.
REQ-039 hsync held low while locked -> lock lost when p_h hits 1023; err_cnt increments; pix_valid stays 0.
REQ-040 Frame of 524 lines -> v_total_meas=524, lock lost at that vsync rise; 256 forced losses -> err_cnt stays 255.
REQ-041 sys_rst_n=0 for one cycle mid-frame while locked -> all outputs 0 next cycle, locked=0, err_cnt=0, lock_lost not pulsed.

Source files
------------

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures hsync/vsync cadence, locks onto the expected
// raster after a run of good frames, and forwards active-window pixels with
// their coordinates one cycle later. Lock losses are flagged and counted.
module vga_timing_rx #(
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int H_VALID     = 640,
  parameter int V_VALID     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_lost,
  output logic [7:0]  err_cnt,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas
);

  localparam logic [9:0] CMAX   = 10'd1023;
  localparam logic [9:0] H_EXP  = 10'(H_TOTAL_EXP);
  localparam logic [9:0] V_EXP  = 10'(V_TOTAL_EXP);
  localparam logic [9:0] H_LO   = 10'(H_ACT_START);
  localparam logic [9:0] H_HI   = 10'(H_ACT_START + H_VALID);
  localparam logic [9:0] V_LO   = 10'(V_ACT_START);
  localparam logic [9:0] V_HI   = 10'(V_ACT_START + V_VALID);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CMAX) ? CMAX : v + 10'd1;
  endfunction

  state_e      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  ph_q, ph_d, pv_q, pv_d;
  logic        seen_h_q, seen_h_d, seen_v_q, seen_v_d;
  logic [9:0]  h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  gf_q, gf_d;
  logic        lost_q, lost_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic        fs_q, fs_d;

  logic       h_rise, v_rise, line_err, frame_bad, lock_err, in_win;
  logic [9:0] h_len, v_len;
  logic [7:0] gf_inc;

  // Raster position, measurements, lock FSM next-state and pixel capture.
  always_comb begin
    h_rise      = hsync & ~hs_prev_q;
    v_rise      = vsync & ~vs_prev_q;
    // Position of the current cycle; ph_q/pv_q hold the previous cycle's.
    ph_d        = h_rise ? 10'd0 : sat_inc(ph_q);
    pv_d        = h_rise ? (v_rise ? 10'd0 : sat_inc(pv_q)) : pv_q;
    h_len       = sat_inc(ph_q);
    v_len       = sat_inc(pv_q);
    seen_h_d    = seen_h_q | h_rise;
    seen_v_d    = seen_v_q | v_rise;
    h_meas_d    = (h_rise & seen_h_q) ? h_len : h_meas_q;
    v_meas_d    = (v_rise & seen_v_q) ? v_len : v_meas_q;

    // Line length is only trusted once a full line has been seen.
    line_err    = (h_rise & seen_h_q & (h_len != H_EXP)) | (ph_d == CMAX);
    frame_bad   = frame_err_q | line_err | ~h_rise |
                  (seen_v_q & (v_len != V_EXP));
    // The h_rise that coincides with v_rise closes the old frame, so the
    // sticky flag restarts clean for the new one.
    frame_err_d = v_rise ? 1'b0 : (frame_err_q | line_err);

    gf_inc      = (gf_q == 8'hFF) ? gf_q : gf_q + 8'd1;
    state_d     = state_q;
    gf_d        = gf_q;
    lost_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    lock_err    = 1'b0;

    case (state_q)
      SEARCH: begin
        if (v_rise & h_rise) begin
          state_d = MEASURE;
          gf_d    = 8'd0;
        end
      end
      MEASURE: begin
        if (v_rise) begin
          if (frame_bad) begin
            gf_d = 8'd0;
          end else begin
            gf_d = gf_inc;
            if (gf_inc >= LOCK_N) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        lock_err = line_err | (v_rise & frame_bad);
        if (lock_err) begin
          state_d   = SEARCH;
          lost_d    = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    in_win      = (state_q == LOCKED) &&
                  (ph_d >= H_LO) && (ph_d < H_HI) &&
                  (pv_d >= V_LO) && (pv_d < V_HI);
    // A sample taken in the cycle lock is dropped is not trusted.
    pix_valid_d = in_win & ~lock_err;
    pix_x_d     = pix_valid_d ? ph_d - H_LO : 10'd0;
    pix_y_d     = pix_valid_d ? pv_d - V_LO : 10'd0;
    pix_data_d  = pix_valid_d ? vga_rgb : 12'd0;
    fs_d        = pix_valid_d & (ph_d == H_LO) & (pv_d == V_LO);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q     <= SEARCH;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      ph_q        <= 10'd0;
      pv_q        <= 10'd0;
      seen_h_q    <= 1'b0;
      seen_v_q    <= 1'b0;
      h_meas_q    <= 10'd0;
      v_meas_q    <= 10'd0;
      frame_err_q <= 1'b0;
      gf_q        <= 8'd0;
      lost_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 10'd0;
      pix_y_q     <= 10'd0;
      pix_data_q  <= 12'd0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hsync;
      vs_prev_q   <= vsync;
      ph_q        <= ph_d;
      pv_q        <= pv_d;
      seen_h_q    <= seen_h_d;
      seen_v_q    <= seen_v_d;
      h_meas_q    <= h_meas_d;
      v_meas_q    <= v_meas_d;
      frame_err_q <= frame_err_d;
      gf_q        <= gf_d;
      lost_q      <= lost_d;
      err_cnt_q   <= err_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      fs_q        <= fs_d;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_data     = pix_data_q;
  assign frame_start  = fs_q;
  assign locked       = (state_q == LOCKED);
  assign lock_lost    = lost_q;
  assign err_cnt      = err_cnt_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;

endmodule
